// File: rtl/boxcar_decimator_if.sv
// Output stream of the boxcar decimator: decimated sample with valid/ready handshake.
interface boxcar_decimator_if;
  logic signed [7:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/boxcar_decimator.sv
// Integrate-and-dump decimator by 2^DECIM_LOG2 feeding a 2-entry output FIFO.
// Optional round-half-up before the shift: define BOXCAR_DECIMATOR_ROUNDING_EN.
module boxcar_decimator #(
  parameter int DECIM_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_ce,
  input  logic signed [7:0]   data_in,
  output logic                o_overflow,
  input  logic                i_clr_ovf,
  boxcar_decimator_if.master  bus
);
  localparam int DATA_W = 8;
  localparam int ACC_W  = DATA_W + DECIM_LOG2;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic [DECIM_LOG2-1:0]    ph;
  logic signed [DATA_W-1:0] mem [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               count;
  logic                     dump;
  logic                     pop;
  logic                     push;
  logic                     drop;
  logic signed [DATA_W-1:0] result;

  // Block average; the widened sum cannot overflow even with the round constant added.
  function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] t;
`ifdef BOXCAR_DECIMATOR_ROUNDING_EN
    t = s + ACC_W'(1 << (DECIM_LOG2 - 1));
`else
    t = s;
`endif
    t = t >>> DECIM_LOG2;
    return t[DATA_W-1:0];
  endfunction

  assign sum    = acc + $signed({{DECIM_LOG2{data_in[DATA_W-1]}}, data_in});
  assign result = scale(sum);
  assign dump   = i_ce && (ph == '1);
  assign pop    = bus.o_valid && bus.i_ready;
  // A full FIFO still accepts the dump when the head leaves in the same cycle.
  assign push   = dump && ((count != 2'd2) || pop);
  assign drop   = dump && (count == 2'd2) && !pop;

  assign bus.o_valid = (count != 2'd0);
  assign bus.o_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      ph         <= '0;
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      o_overflow <= 1'b0;
    end else begin
      if (i_ce) begin
        if (dump) begin
          acc <= '0;
          ph  <= '0;
        end else begin
          acc <= sum;
          ph  <= ph + 1'b1;
        end
      end
      if (push) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // A fresh drop outranks a clear request in the same cycle.
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        o_overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed plus randomized bench for boxcar_decimator against a queue-based block-average model.
module tb_boxcar_decimator;
  localparam int L = 2;
  localparam int N = 1 << L;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              i_ce = 1'b0;
  logic signed [7:0] data_in = '0;
  logic              o_overflow;
  logic              i_clr_ovf = 1'b0;

  boxcar_decimator_if bus ();

  boxcar_decimator #(.DECIM_LOG2(L)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_ce       (i_ce),
    .data_in    (data_in),
    .o_overflow (o_overflow),
    .i_clr_ovf  (i_clr_ovf),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    blk[$];
  int    exp_q[$];
  bit    exp_ovf = 1'b0;
  string phase = "init";

  // Mean of one block, floor division (plus half-step when rounding is built in).
  function automatic int block_avg(input int b[$]);
    int s = 0;
    int q;
    foreach (b[i]) s += b[i];
`ifdef BOXCAR_DECIMATOR_ROUNDING_EN
    s += N / 2;
`endif
    q = s / N;
    if ((s % N) != 0 && s < 0) q -= 1;
    return q;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, expv);
    end
  endtask

  task automatic step(input bit ce, input int din, input bit rdy, input bit clr);
    bit pop;
    bit dump;
    bit drop;
    int res;
    i_ce        = ce;
    data_in     = din[7:0];
    bus.i_ready = rdy;
    i_clr_ovf   = clr;
    @(posedge clk);
    pop  = (exp_q.size() != 0) && rdy;
    dump = 1'b0;
    drop = 1'b0;
    res  = 0;
    if (ce) begin
      blk.push_back(din);
      if (blk.size() == N) begin
        res = block_avg(blk);
        blk.delete();
        dump = 1'b1;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (dump) begin
      if (exp_q.size() < 2) exp_q.push_back(res);
      else drop = 1'b1;
    end
    if (drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    #1;
    chk("valid", bus.o_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("data", bus.o_data, exp_q[0]);
    chk("ovf", o_overflow, exp_ovf);
  endtask

  task automatic block(input int a, input int b, input int c, input int d, input bit rdy);
    step(1'b1, a, rdy, 1'b0);
    step(1'b1, b, rdy, 1'b0);
    step(1'b1, c, rdy, 1'b0);
    step(1'b1, d, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy, input bit clr);
    for (int i = 0; i < n; i++) step(1'b0, 0, rdy, clr);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_ovf", o_overflow, 0);
    blk.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    bus.i_ready = 1'b0;
    phase = "reset";
    #12;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    phase = "basic";
    block(10, 20, 30, 41, 1'b1);
    chk("avg_25", bus.o_data, 25);
    block(1, 1, 1, 0, 1'b1);
    idle(2, 1'b1, 1'b0);

    phase = "extremes";
    block(-128, -128, -128, -128, 1'b1);
    chk("min", bus.o_data, -128);
    block(127, 127, 127, 127, 1'b1);
    chk("max", bus.o_data, 127);
    block(-1, 0, 0, 0, 1'b1);
    idle(2, 1'b1, 1'b0);

    phase = "backpressure";
    block(5, 5, 5, 5, 1'b0);
    block(6, 6, 6, 6, 1'b0);
    block(7, 7, 7, 7, 1'b0);
    chk("hold5", bus.o_data, 5);
    chk("ovf_set", o_overflow, 1);
    idle(3, 1'b1, 1'b0);

    phase = "clear_idle";
    idle(1, 1'b0, 1'b1);
    chk("ovf_cleared", o_overflow, 0);

    phase = "pushpop_full";
    block(5, 5, 5, 5, 1'b0);
    block(6, 6, 6, 6, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 9, 1'b0, 1'b0);
    step(1'b1, 9, 1'b1, 1'b0);
    chk("head6", bus.o_data, 6);
    chk("no_ovf", o_overflow, 0);
    idle(3, 1'b1, 1'b0);

    phase = "ovf_vs_clr";
    block(3, 3, 3, 3, 1'b0);
    block(4, 4, 4, 4, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b0);
    step(1'b1, 2, 1'b0, 1'b1);
    chk("ovf_wins", o_overflow, 1);
    idle(1, 1'b1, 1'b1);
    idle(2, 1'b1, 1'b0);

    phase = "reset_mid";
    step(1'b1, 50, 1'b1, 1'b0);
    step(1'b1, 50, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    block(8, 8, 8, 8, 1'b1);
    chk("fresh8", bus.o_data, 8);
    idle(1, 1'b1, 1'b0);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      int d;
      d = (i % 37 == 0) ? -128 : (i % 41 == 0) ? 127 : int'($urandom_range(0, 255)) - 128;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    idle(4, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/boxcar_decimator.md
# boxcar_decimator

- Integrate-and-dump decimator that sits directly downstream of the two-tap average filter.
- Consumes the filter's 8-bit signed samples on their `o_ce` strobe, sums each block of 2^DECIM_LOG2 consecutive samples, and emits one averaged 8-bit sample per block.
- Output samples go into a 2-entry output FIFO with a valid/ready handshake, so a stalling consumer does not lose data until the FIFO fills.

## Interface
- `DECIM_LOG2`, default 2: log2 of the decimation ratio N. Legal range 1..4 (N = 2..16).
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `i_ce` input 1: sample strobe, driven by the upstream filter's `o_ce`.
- `data_in` input 8: signed sample, driven by the upstream `data_out`; sampled only when `i_ce`=1.
- `o_data` output 8: signed decimated sample at the FIFO head.
- `o_valid` output 1: FIFO non-empty; `o_data` is valid.
- `i_ready` input 1: consumer accepts `o_data` this cycle.
- `o_overflow` output 1: sticky flag; set when a completed block is dropped because the FIFO was full.
- `i_clr_ovf` input 1: synchronous clear of `o_overflow`.

## Operation
- **Accumulator `acc`**
  - Signed, 8+DECIM_LOG2 bits; no overflow is possible.
  - Phase counter `ph` is DECIM_LOG2 bits and counts accepted `i_ce` samples.
- **On `i_ce` with `ph` < N-1:** `acc <= acc + data_in` and `ph <= ph+1`.
- **On `i_ce` with `ph` = N-1 (dump):**
  - Result = (acc + data_in [+ round constant]) >>> DECIM_LOG2, giving an 8-bit signed value.
  - The result is pushed to the FIFO.
  - `acc <= 0`, `ph <= 0`.
  - The arithmetic shift truncates toward −∞; the result always fits in 8 bits.
- **FIFO**
  - 2 entries, with write pointer, read pointer and count (0..2).
  - Pop when `o_valid && i_ready`. Push on dump.
  - Dump while count=2 and no pop in the same cycle: the sample is discarded, `o_overflow` is set, and count is unchanged.
  - Dump while count=2 and pop in the same cycle: push is accepted, count stays 2, no overflow.
  - Push and pop with count=1: count stays 1, and the head advances to the new sample.
  - Pop when count=0 is impossible because `o_valid`=0.
- **`o_data` source:** driven from the FIFO head register. When empty it holds the last popped value (don't-care).
- **`o_overflow`:** stays set until `i_clr_ovf`=1. If a new overflow and `i_clr_ovf` occur in the same cycle, the overflow wins and the flag stays 1.
- **Idle input:** `i_ce` low holds all state.
- **Reset:** `reset_n` low asynchronously clears `acc`, `ph`, the FIFO pointers and count, and `o_overflow`. A partially accumulated block is discarded. After release, accumulation restarts at `ph`=0.

## Timing
- **Reset values:** `o_valid`=0, `o_data`=0, `o_overflow`=0.
- **Latency:** the dump sample's edge (`i_ce` high on the Nth sample) is edge k. `o_valid`=1 and `o_data`=result are visible after edge k, i.e. 1 cycle.
- **Throughput:** one output per N input strobes.
  - `i_ce` may be high every cycle.
  - With `i_ready` held high the FIFO never exceeds 1 entry.
- **Handshake:**
  - `o_data` and `o_valid` are stable while `o_valid`=1 and `i_ready`=0.
  - `i_ready` may toggle freely; it has no combinational path to `o_valid`.
- **Reset release:** removal is synchronised externally by the system. The block does not rely on `i_ce` being low at release.

## Configuration
- **Macro:** `BOXCAR_DECIMATOR_ROUNDING_EN`.
- **Defined:** the constant 2^(DECIM_LOG2-1) is added to the sum before the shift, giving round-half-up.
  - Worst-case sums still fit in 8 bits (max 127, min −128); no saturation logic is needed.
- **Undefined:** plain arithmetic-shift truncation toward −∞.

## Test plan
- **Basic dump:** DECIM_LOG2=2, `i_ready`=1, `i_ce` every cycle with samples 10, 20, 30, 41.
  - One output of 25: truncation of 101/4 (both builds), since 101+2 >>> 2 also = 25.
  - Next block 1, 1, 1, 0 (sum 3) → 0 truncated, 1 with rounding.
- **Negative and extremes:** 4×(−128) → −128. 4×127 → 127. Block −1, 0, 0, 0 → −1 truncated, 0 with rounding.
- **Backpressure:** `i_ready`=0 and 3 complete blocks with results 5, 6, 7.
  - `o_valid`=1 holding 5; the FIFO holds 5 and 6.
  - Block 7 is dropped and `o_overflow`=1.
  - Raising `i_ready` then yields 5, 6 in consecutive cycles, then `o_valid`=0.
- **Simultaneous push/pop at full:** FIFO holds 5 and 6.
  - In the same cycle, a dump of 9 arrives and `i_ready`=1.
  - Pops 5, no overflow; the subsequent sequence is 6, 9.
- **Overflow vs clear:** `i_clr_ovf`=1 with no overflow → flag 0. `i_clr_ovf`=1 coincident with a dropped dump → flag stays 1.
- **Reset mid-block:**
  - Feed 2 of 4 samples (50, 50), then pulse `reset_n` low asynchronously between edges.
  - All outputs go to 0 immediately.
  - Feed 4×8 → output 8; the partial sum is not carried over.
